// File: rtl/oyun_yoneticisi.sv
// oyun_yoneticisi: turn scheduler and score keeper for the three-player
// kapisma datapath. Collects one move per player through a valid/ready
// handshake and presents the packed step vectors for one evaluation cycle.
// It then adds the round winner's points and declares a champion after
// TUR_SAYISI rounds.
// Optional feature: define ZAMAN_ASIMI_EN to enable the per-turn move timeout.
module oyun_yoneticisi #(
    parameter int unsigned TUR_SAYISI  = 4,
    parameter int unsigned ZAMAN_ASIMI = 15,
    parameter int unsigned SKOR_GEN    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                basla,
    input  logic [3:0]          sayi_giris,
    input  logic                hamle_gecerli,
    output logic                hamle_hazir,
    input  logic [1:0]          hamle_sag,
    input  logic [1:0]          hamle_asagi,
    output logic [1:0]          sira,
    output logic [5:0]          k_sag_adimlar,
    output logic [5:0]          k_asagi_adimlar,
    output logic [3:0]          k_sayi,
    input  logic [1:0]          k_kazanan,
    input  logic [4:0]          k_toplam_puan,
    output logic [3:0]          tur_sayac,
    output logic [SKOR_GEN-1:0] skor1,
    output logic [SKOR_GEN-1:0] skor2,
    output logic [SKOR_GEN-1:0] skor3,
    output logic                oyun_bitti,
    output logic [1:0]          sampiyon
);

    if (TUR_SAYISI < 1 || TUR_SAYISI > 15) begin : g_tur_sayisi_hatali
        $error("oyun_yoneticisi: TUR_SAYISI must be within 1..15");
    end
    if (ZAMAN_ASIMI < 2 || ZAMAN_ASIMI > 255) begin : g_zaman_asimi_hatali
        $error("oyun_yoneticisi: ZAMAN_ASIMI must be within 2..255");
    end
    if (SKOR_GEN < 5) begin : g_skor_gen_hatali
        $error("oyun_yoneticisi: SKOR_GEN must be at least 5");
    end

    typedef enum logic [2:0] {
        BOSTA,
        HAMLE,
        DEGERLENDIR,
        GUNCELLE,
        BITTI
    } durum_t;

    durum_t              durum;
    logic [1:0]          yakalanan_kazanan;
    logic [4:0]          yakalanan_puan;
    logic                kabul;
    logic                zaman_doldu;
    logic                sira_ilerle;
    logic [SKOR_GEN-1:0] yeni_skor1;
    logic [SKOR_GEN-1:0] yeni_skor2;
    logic [SKOR_GEN-1:0] yeni_skor3;
    logic [1:0]          yeni_sampiyon;

`ifdef ZAMAN_ASIMI_EN
    logic [7:0]          zaman;
`endif

    // Add zero-extended points to a score, clamping at the all-ones value
    function automatic logic [SKOR_GEN-1:0] doygun_topla(
        input logic [SKOR_GEN-1:0] skor,
        input logic [4:0]          puan
    );
        logic [SKOR_GEN:0] toplam;
        toplam = {1'b0, skor} + (SKOR_GEN+1)'(puan);
        return toplam[SKOR_GEN] ? '1 : toplam[SKOR_GEN-1:0];
    endfunction

    // Highest score wins; ties go 1 > 3 > 2; no points at all means no champion
    function automatic logic [1:0] sampiyon_sec(
        input logic [SKOR_GEN-1:0] s1,
        input logic [SKOR_GEN-1:0] s2,
        input logic [SKOR_GEN-1:0] s3
    );
        if (s1 == '0 && s2 == '0 && s3 == '0)
            return 2'd0;
        else if (s1 >= s2 && s1 >= s3)
            return 2'd1;
        else if (s3 >= s2)
            return 2'd3;
        else
            return 2'd2;
    endfunction

    // Turn advance: a handshake, or the turn running out of time
    always_comb begin
        kabul       = (durum == HAMLE) && hamle_gecerli && hamle_hazir;
        zaman_doldu = 1'b0;
`ifdef ZAMAN_ASIMI_EN
        zaman_doldu = (durum == HAMLE) && (zaman == 8'(ZAMAN_ASIMI - 1));
`endif
        sira_ilerle = kabul || zaman_doldu;
    end

    // Scores after applying the captured round result, and the champion they imply
    always_comb begin
        yeni_skor1 = skor1;
        yeni_skor2 = skor2;
        yeni_skor3 = skor3;
        case (yakalanan_kazanan)
            2'd1:    yeni_skor1 = doygun_topla(skor1, yakalanan_puan);
            2'd2:    yeni_skor2 = doygun_topla(skor2, yakalanan_puan);
            2'd3:    yeni_skor3 = doygun_topla(skor3, yakalanan_puan);
            default: ;
        endcase
        yeni_sampiyon = sampiyon_sec(yeni_skor1, yeni_skor2, yeni_skor3);
    end

    // Game sequencing with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum             <= BOSTA;
            hamle_hazir       <= 1'b0;
            sira              <= '0;
            k_sag_adimlar     <= '0;
            k_asagi_adimlar   <= '0;
            k_sayi            <= '0;
            tur_sayac         <= '0;
            skor1             <= '0;
            skor2             <= '0;
            skor3             <= '0;
            oyun_bitti        <= 1'b0;
            sampiyon          <= '0;
            yakalanan_kazanan <= '0;
            yakalanan_puan    <= '0;
`ifdef ZAMAN_ASIMI_EN
            zaman             <= '0;
`endif
        end else begin
            case (durum)
                BOSTA, BITTI: begin
                    if (basla) begin
                        skor1           <= '0;
                        skor2           <= '0;
                        skor3           <= '0;
                        tur_sayac       <= '0;
                        sampiyon        <= '0;
                        oyun_bitti      <= 1'b0;
                        k_sag_adimlar   <= '0;
                        k_asagi_adimlar <= '0;
                        k_sayi          <= sayi_giris;
                        sira            <= 2'd1;
                        hamle_hazir     <= 1'b1;
                        durum           <= HAMLE;
`ifdef ZAMAN_ASIMI_EN
                        zaman           <= '0;
`endif
                    end
                end

                HAMLE: begin
                    // A handshake on the timeout cycle still writes its move
                    if (kabul) begin
                        case (sira)
                            2'd1: begin
                                k_sag_adimlar[5:4]   <= hamle_sag;
                                k_asagi_adimlar[5:4] <= hamle_asagi;
                            end
                            2'd2: begin
                                k_sag_adimlar[3:2]   <= hamle_sag;
                                k_asagi_adimlar[3:2] <= hamle_asagi;
                            end
                            2'd3: begin
                                k_sag_adimlar[1:0]   <= hamle_sag;
                                k_asagi_adimlar[1:0] <= hamle_asagi;
                            end
                            default: ;
                        endcase
                    end
                    if (sira_ilerle) begin
`ifdef ZAMAN_ASIMI_EN
                        zaman <= '0;
`endif
                        if (sira == 2'd3) begin
                            sira        <= '0;
                            hamle_hazir <= 1'b0;
                            durum       <= DEGERLENDIR;
                        end else begin
                            sira <= sira + 2'd1;
                        end
                    end
`ifdef ZAMAN_ASIMI_EN
                    else begin
                        zaman <= zaman + 8'd1;
                    end
`endif
                end

                DEGERLENDIR: begin
                    yakalanan_kazanan <= k_kazanan;
                    yakalanan_puan    <= k_toplam_puan;
                    durum             <= GUNCELLE;
                end

                GUNCELLE: begin
                    skor1     <= yeni_skor1;
                    skor2     <= yeni_skor2;
                    skor3     <= yeni_skor3;
                    tur_sayac <= tur_sayac + 4'd1;
                    if (tur_sayac + 4'd1 == 4'(TUR_SAYISI)) begin
                        oyun_bitti <= 1'b1;
                        sampiyon   <= yeni_sampiyon;
                        durum      <= BITTI;
                    end else begin
                        k_sag_adimlar   <= '0;
                        k_asagi_adimlar <= '0;
                        k_sayi          <= sayi_giris;
                        sira            <= 2'd1;
                        hamle_hazir     <= 1'b1;
                        durum           <= HAMLE;
                    end
                end

                default: durum <= BOSTA;
            endcase
        end
    end

endmodule

// File: tb/tb_oyun_yoneticisi.sv
// Directed bench for oyun_yoneticisi. The main instance runs the default
// 4-round game. A second instance with 11 rounds drives a score into
// saturation.
module tb_oyun_yoneticisi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst2, basla, hamle_gecerli;
    logic [3:0] sayi_giris;
    logic [1:0] hamle_sag, hamle_asagi, k_kazanan;
    logic [4:0] k_toplam_puan;

    logic       hamle_hazir, oyun_bitti;
    logic [1:0] sira, sampiyon;
    logic [5:0] k_sag_adimlar, k_asagi_adimlar;
    logic [3:0] k_sayi, tur_sayac;
    logic [7:0] skor1, skor2, skor3;

    logic       d2_hamle_hazir, d2_oyun_bitti;
    logic [1:0] d2_sira, d2_sampiyon;
    logic [5:0] d2_k_sag_adimlar, d2_k_asagi_adimlar;
    logic [3:0] d2_k_sayi, d2_tur_sayac;
    logic [7:0] d2_skor1, d2_skor2, d2_skor3;

    int test_sayisi = 0;
    int hata_sayisi = 0;

    oyun_yoneticisi dut (
        .clk(clk), .rst(rst), .basla(basla), .sayi_giris(sayi_giris),
        .hamle_gecerli(hamle_gecerli), .hamle_hazir(hamle_hazir),
        .hamle_sag(hamle_sag), .hamle_asagi(hamle_asagi), .sira(sira),
        .k_sag_adimlar(k_sag_adimlar), .k_asagi_adimlar(k_asagi_adimlar),
        .k_sayi(k_sayi), .k_kazanan(k_kazanan), .k_toplam_puan(k_toplam_puan),
        .tur_sayac(tur_sayac), .skor1(skor1), .skor2(skor2), .skor3(skor3),
        .oyun_bitti(oyun_bitti), .sampiyon(sampiyon)
    );

    oyun_yoneticisi #(.TUR_SAYISI(11), .ZAMAN_ASIMI(15), .SKOR_GEN(8)) dut2 (
        .clk(clk), .rst(rst2), .basla(basla), .sayi_giris(sayi_giris),
        .hamle_gecerli(hamle_gecerli), .hamle_hazir(d2_hamle_hazir),
        .hamle_sag(hamle_sag), .hamle_asagi(hamle_asagi), .sira(d2_sira),
        .k_sag_adimlar(d2_k_sag_adimlar), .k_asagi_adimlar(d2_k_asagi_adimlar),
        .k_sayi(d2_k_sayi), .k_kazanan(k_kazanan), .k_toplam_puan(k_toplam_puan),
        .tur_sayac(d2_tur_sayac), .skor1(d2_skor1), .skor2(d2_skor2), .skor3(d2_skor3),
        .oyun_bitti(d2_oyun_bitti), .sampiyon(d2_sampiyon)
    );

    task automatic kontrol(input string etiket, input int gozlenen, input int beklenen);
        test_sayisi++;
        if (gozlenen != beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: observed %0d, expected %0d", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hamle(input logic [1:0] sag, input logic [1:0] asagi);
        hamle_gecerli = 1'b1;
        hamle_sag     = sag;
        hamle_asagi   = asagi;
        tick();
        hamle_gecerli = 1'b0;
    endtask

    // One full round with all-zero moves; ends one cycle into the next round
    task automatic tur(input logic [1:0] kaz, input logic [4:0] puan, input logic [3:0] sonraki);
        k_kazanan     = kaz;
        k_toplam_puan = puan;
        hamle(2'd0, 2'd0);
        hamle(2'd0, 2'd0);
        hamle(2'd0, 2'd0);
        tick();
        sayi_giris = sonraki;
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rst2 = 1'b1; basla = 1'b0; hamle_gecerli = 1'b0;
        sayi_giris = '0; hamle_sag = '0; hamle_asagi = '0;
        k_kazanan = '0; k_toplam_puan = '0;

        // Reset state
        repeat (5) tick();
        kontrol("reset_sira", int'(sira), 0);
        kontrol("reset_hazir", int'(hamle_hazir), 0);
        kontrol("reset_k", int'({k_sag_adimlar, k_asagi_adimlar, k_sayi}), 0);
        kontrol("reset_skor", int'({skor1, skor2, skor3}), 0);
        kontrol("reset_son", int'({tur_sayac, oyun_bitti, sampiyon}), 0);

        rst = 1'b0;
        tick();
        sayi_giris = 4'd9;
        basla = 1'b1;
        tick();
        basla = 1'b0;
        kontrol("basla_sira", int'(sira), 1);
        kontrol("basla_hazir", int'(hamle_hazir), 1);
        kontrol("basla_sayi", int'(k_sayi), 9);

        // Round 1: P1=(1,2) P2=(3,0) P3=(0,1), winner 3 with 7
        k_kazanan = 2'd3; k_toplam_puan = 5'd7;
        hamle(2'd1, 2'd2);
        kontrol("r1_sira2", int'(sira), 2);
        hamle(2'd3, 2'd0);
        kontrol("r1_sira3", int'(sira), 3);
        hamle(2'd0, 2'd1);
        kontrol("r1_sira0", int'(sira), 0);
        kontrol("r1_hazir0", int'(hamle_hazir), 0);
        kontrol("r1_k_sag", int'(k_sag_adimlar), int'(6'b011100));
        kontrol("r1_k_asagi", int'(k_asagi_adimlar), int'(6'b100001));
        kontrol("r1_k_sayi", int'(k_sayi), 9);
        tick();
        // Result already captured; changing the inputs must not matter
        k_kazanan = 2'd0; k_toplam_puan = 5'd0;
        sayi_giris = 4'd4;
        tick();
        kontrol("r1_skor3", int'(skor3), 7);
        kontrol("r1_skor1", int'(skor1), 0);
        kontrol("r1_tur", int'(tur_sayac), 1);
        kontrol("r2_sira", int'(sira), 1);
        kontrol("r2_hazir", int'(hamle_hazir), 1);
        kontrol("r2_sayi", int'(k_sayi), 4);
        kontrol("r2_slot_bos", int'(k_sag_adimlar), 0);

        // Round 2: P1=(2,1), P2 silent, P3=(1,1); winner 1 with 12
        k_kazanan = 2'd1; k_toplam_puan = 5'd12;
        hamle(2'd2, 2'd1);
        kontrol("r2_sira2", int'(sira), 2);
`ifdef ZAMAN_ASIMI_EN
        repeat (14) tick();
        kontrol("to_p2_bekle", int'(sira), 2);
        tick();
        kontrol("to_p2_ilerle", int'(sira), 3);
        kontrol("to_p2_sag", int'(k_sag_adimlar), int'(6'b100000));
        kontrol("to_p2_asagi", int'(k_asagi_adimlar), int'(6'b010000));
        repeat (14) tick();
        kontrol("to_p3_bekle", int'(sira), 3);
        hamle(2'd1, 2'd1);
`else
        hamle(2'd0, 2'd0);
        hamle(2'd1, 2'd1);
`endif
        kontrol("r2_sira0", int'(sira), 0);
        kontrol("r2_k_sag", int'(k_sag_adimlar), int'(6'b100001));
        kontrol("r2_k_asagi", int'(k_asagi_adimlar), int'(6'b010001));
        tick();
        sayi_giris = 4'd6;
        tick();
        kontrol("r2_skor1", int'(skor1), 12);
        kontrol("r2_tur", int'(tur_sayac), 2);

        // Round 3: basla ignored mid-game; winner 2 with 5
        basla = 1'b1;
        tick();
        basla = 1'b0;
        kontrol("r3_basla_yok", int'(sira), 1);
        kontrol("r3_basla_tur", int'(tur_sayac), 2);
        k_kazanan = 2'd2; k_toplam_puan = 5'd5;
        hamle(2'd1, 2'd1);
        hamle(2'd2, 2'd2);
        hamle(2'd3, 2'd3);
        kontrol("r3_k_sag", int'(k_sag_adimlar), int'(6'b011011));
        // Move offered during evaluation must be ignored
        hamle(2'd0, 2'd0);
        kontrol("r3_gecersiz", int'(k_sag_adimlar), int'(6'b011011));
        sayi_giris = 4'd2;
        tick();
        kontrol("r3_skor2", int'(skor2), 5);
        kontrol("r3_tur", int'(tur_sayac), 3);

        // Round 4: winner 3 with 5 -> 12/5/12, tie 1 vs 3 goes to 1
        tur(2'd3, 5'd5, 4'd0);
        kontrol("son_bitti", int'(oyun_bitti), 1);
        kontrol("son_sampiyon", int'(sampiyon), 1);
        kontrol("son_tur", int'(tur_sayac), 4);
        kontrol("son_skor", int'({skor1, skor2, skor3}), int'({8'd12, 8'd5, 8'd12}));
        kontrol("son_sira", int'({sira, hamle_hazir}), 0);
        tick();
        kontrol("son_tutulur", int'(oyun_bitti), 1);

        // Restart from BITTI
        sayi_giris = 4'd5;
        basla = 1'b1;
        tick();
        basla = 1'b0;
        kontrol("yeni_skor", int'({skor1, skor2, skor3}), 0);
        kontrol("yeni_tur", int'(tur_sayac), 0);
        kontrol("yeni_sira", int'(sira), 1);
        kontrol("yeni_bitti", int'({oyun_bitti, sampiyon}), 0);
        kontrol("yeni_sayi", int'(k_sayi), 5);

        // Score a round, then reset asynchronously during P2's turn
        tur(2'd3, 5'd7, 4'd8);
        kontrol("yeni_skor3", int'(skor3), 7);
        hamle(2'd1, 2'd0);
        kontrol("rst_once_sira", int'(sira), 2);
        #3 rst = 1'b1;
        #1;
        kontrol("rst_asenk_sira", int'(sira), 0);
        kontrol("rst_asenk_skor", int'(skor3), 0);
        kontrol("rst_asenk_k", int'({k_sag_adimlar, k_sayi, tur_sayac, hamle_hazir}), 0);
        tick();
        rst = 1'b0;
        hamle_gecerli = 1'b1;
        tick();
        hamle_gecerli = 1'b0;
        kontrol("rst_sonra_bosta", int'({sira, hamle_hazir}), 0);
        kontrol("rst_sonra_k", int'(k_sag_adimlar), 0);

        // Saturation on the 11-round instance
        rst = 1'b1;
        rst2 = 1'b0;
        tick();
        sayi_giris = 4'd1;
        basla = 1'b1;
        tick();
        basla = 1'b0;
        kontrol("d2_basla", int'(d2_sira), 1);
        repeat (8) tur(2'd1, 5'd31, 4'd1);
        kontrol("d2_skor1_248", int'(d2_skor1), 248);
        tur(2'd0, 5'd20, 4'd1);
        kontrol("d2_kazanan_yok", int'(d2_skor1), 248);
        kontrol("d2_digerleri", int'({d2_skor2, d2_skor3}), 0);
        kontrol("d2_tur9", int'(d2_tur_sayac), 9);
        tur(2'd1, 5'd2, 4'd1);
        kontrol("d2_skor1_250", int'(d2_skor1), 250);
        tur(2'd1, 5'd10, 4'd1);
        kontrol("d2_doyma", int'(d2_skor1), 255);
        kontrol("d2_bitti", int'(d2_oyun_bitti), 1);
        kontrol("d2_sampiyon", int'(d2_sampiyon), 1);
        kontrol("d2_tur11", int'(d2_tur_sayac), 11);

        $display("[TB] %0d tests run, %0d failed", test_sayisi, hata_sayisi);
        $finish;
    end

endmodule
